// File: rtl/e203_exu_wbck_arb_if.sv
// e203_exu_wbck_arb_if: ALU, long-pipe and regfile-write signals of the writeback arbiter
interface e203_exu_wbck_arb_if #(
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 5
);
    logic               alu_wbck_i_valid;
    logic               alu_wbck_i_ready;
    logic [RFIDX_W-1:0] alu_wbck_i_idx;
    logic [XLEN-1:0]    alu_wbck_i_dat;
    logic               longp_wbck_i_valid;
    logic               longp_wbck_i_ready;
    logic [RFIDX_W-1:0] longp_wbck_i_idx;
    logic [XLEN-1:0]    longp_wbck_i_dat;
    logic               longp_wbck_i_err;
    logic               wbck_dest_wen;
    logic [RFIDX_W-1:0] wbck_dest_idx;
    logic [XLEN-1:0]    wbck_dest_dat;
    logic               longp_err_o;
    logic               longp_empty;
    logic               longp_full;

    modport slave (
        input  alu_wbck_i_valid, alu_wbck_i_idx, alu_wbck_i_dat,
               longp_wbck_i_valid, longp_wbck_i_idx, longp_wbck_i_dat, longp_wbck_i_err,
        output alu_wbck_i_ready, longp_wbck_i_ready,
               wbck_dest_wen, wbck_dest_idx, wbck_dest_dat,
               longp_err_o, longp_empty, longp_full
    );

    modport master (
        output alu_wbck_i_valid, alu_wbck_i_idx, alu_wbck_i_dat,
               longp_wbck_i_valid, longp_wbck_i_idx, longp_wbck_i_dat, longp_wbck_i_err,
        input  alu_wbck_i_ready, longp_wbck_i_ready,
               wbck_dest_wen, wbck_dest_idx, wbck_dest_dat,
               longp_err_o, longp_empty, longp_full
    );
endinterface

// File: rtl/e203_exu_wbck_arb.sv
// e203_exu_wbck_arb: regfile writeback arbiter (ALU priority) with a long-pipe result FIFO.
// Optional E203_WBCK_STARVE_GUARD_EN bounds how long the FIFO head can be blocked by the ALU.
module e203_exu_wbck_arb #(
    parameter int XLEN       = 32,
    parameter int RFIDX_W    = 5,
    parameter int LP_DEPTH   = 2,
    parameter int STARVE_MAX = 4
) (
    input logic               clk,
    input logic               rst_n,
    e203_exu_wbck_arb_if.slave wb
);
    localparam int PTR_W = $clog2(LP_DEPTH);
    localparam int ENT_W = 1 + RFIDX_W + XLEN;

    logic [ENT_W-1:0] mem_q [LP_DEPTH];
    logic [ENT_W-1:0] mem_d [LP_DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             empty, full, push, pop, alu_ready, alu_grant, head_err, lp_wr;
    logic [ENT_W-1:0] head;

    assign head      = mem_q[rptr_q];
    assign head_err  = head[ENT_W-1];
    assign empty     = cnt_q == '0;
    assign full      = cnt_q == (PTR_W+1)'(LP_DEPTH);
    assign push      = wb.longp_wbck_i_valid & ~full;
    assign alu_grant = wb.alu_wbck_i_valid & alu_ready;
    assign pop       = ~empty & ~alu_grant;
    assign lp_wr     = pop & ~head_err;

`ifdef E203_WBCK_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_MAX + 1);
    logic [SC_W-1:0] starve_q, starve_d;

    assign alu_ready = starve_q != SC_W'(STARVE_MAX);

    // Count cycles the non-empty head is blocked; saturation forces the ALU off for one cycle.
    always_comb starve_d = pop ? '0 : (!empty && alu_ready) ? starve_q + 1'b1 : starve_q;

    // Starve counter register.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) starve_q <= '0;
        else        starve_q <= starve_d;
`else
    logic [31:0] starve_max_unused;
    assign starve_max_unused = 32'(STARVE_MAX);
    assign alu_ready = 1'b1;
`endif

    // FIFO next state: write at tail on push, advance head on pop.
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wptr_q] = {wb.longp_wbck_i_err, wb.longp_wbck_i_idx, wb.longp_wbck_i_dat};
        wptr_d = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
        cnt_d  = (push && !pop) ? cnt_q + 1'b1 : (pop && !push) ? cnt_q - 1'b1 : cnt_q;
    end

    // FIFO state registers; reset drops every entry.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mem_q  <= '{default: '0};
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end

    // Regfile write mux: ALU first, then a good FIFO head; a faulted head only raises the error pulse.
    always_comb begin
        wb.alu_wbck_i_ready   = alu_ready;
        wb.longp_wbck_i_ready = ~full;
        wb.longp_empty        = empty;
        wb.longp_full         = full;
        wb.wbck_dest_wen      = alu_grant | lp_wr;
        wb.wbck_dest_idx      = alu_grant ? wb.alu_wbck_i_idx : lp_wr ? head[XLEN +: RFIDX_W] : '0;
        wb.wbck_dest_dat      = alu_grant ? wb.alu_wbck_i_dat : lp_wr ? head[XLEN-1:0] : '0;
        wb.longp_err_o        = pop & head_err;
    end
endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// tb_e203_exu_wbck_arb: scoreboard bench for the writeback arbiter (directed scenarios + write-order monitor)
module tb_e203_exu_wbck_arb;
    localparam int XLEN = 32, RFIDX_W = 5, LP_DEPTH = 2, STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    e203_exu_wbck_arb_if #(.XLEN(XLEN), .RFIDX_W(RFIDX_W)) wb ();

    e203_exu_wbck_arb #(.XLEN(XLEN), .RFIDX_W(RFIDX_W), .LP_DEPTH(LP_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [XLEN+RFIDX_W:0] lp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic alu(input logic v, input logic [RFIDX_W-1:0] idx);
        wb.alu_wbck_i_valid = v;
        wb.alu_wbck_i_idx   = idx;
        wb.alu_wbck_i_dat   = $urandom;
    endtask

    task automatic lp(input logic v, input logic [RFIDX_W-1:0] idx, input logic [XLEN-1:0] dat, input logic err);
        wb.longp_wbck_i_valid = v;
        wb.longp_wbck_i_idx   = idx;
        wb.longp_wbck_i_dat   = dat;
        wb.longp_wbck_i_err   = err;
    endtask

    // Monitor: ALU grants write immediately; every other write or error pulse must match the oldest accepted long-pipe entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wb.alu_wbck_i_valid && wb.alu_wbck_i_ready) begin
                check("alu_wen", wb.wbck_dest_wen, 1);
                check("alu_idx", wb.wbck_dest_idx, wb.alu_wbck_i_idx);
                check("alu_dat", wb.wbck_dest_dat, wb.alu_wbck_i_dat);
            end else if (lp_q.size() > 0 || wb.wbck_dest_wen || wb.longp_err_o) begin
                if (lp_q.size() == 0) check("lp_unexp", {wb.wbck_dest_wen, wb.longp_err_o}, 0);
                else begin
                    logic [XLEN+RFIDX_W:0] e;
                    e = lp_q.pop_front();
                    check("lp_err", wb.longp_err_o, e[XLEN+RFIDX_W]);
                    check("lp_wen", wb.wbck_dest_wen, !e[XLEN+RFIDX_W]);
                    if (!e[XLEN+RFIDX_W]) begin
                        check("lp_idx", wb.wbck_dest_idx, e[XLEN +: RFIDX_W]);
                        check("lp_dat", wb.wbck_dest_dat, e[XLEN-1:0]);
                    end
                end
            end
            if (wb.longp_wbck_i_valid && wb.longp_wbck_i_ready)
                lp_q.push_back({wb.longp_wbck_i_err, wb.longp_wbck_i_idx, wb.longp_wbck_i_dat});
        end
    end

    initial begin
        alu(0, 0);
        wb.alu_wbck_i_dat = '0;
        lp(0, 0, 0, 0);
        repeat (3) cyc();
        rst_n = 1'b1;

        // Idle after reset
        repeat (5) cyc();
        smp();
        check("rst_wen", wb.wbck_dest_wen, 0);
        check("rst_idx", wb.wbck_dest_idx, 0);
        check("rst_dat", wb.wbck_dest_dat, 0);
        check("rst_err", wb.longp_err_o, 0);
        check("rst_empty", wb.longp_empty, 1);
        check("rst_full", wb.longp_full, 0);
        check("rst_alu_rdy", wb.alu_wbck_i_ready, 1);
        check("rst_lp_rdy", wb.longp_wbck_i_ready, 1);

        // ALU write, zero latency
        cyc();
        alu(1, 5);
        wb.alu_wbck_i_dat = 32'h1234_5678;
        smp();
        check("alu5_wen", wb.wbck_dest_wen, 1);
        check("alu5_idx", wb.wbck_dest_idx, 5);
        check("alu5_dat", wb.wbck_dest_dat, 32'h1234_5678);
        cyc();
        alu(0, 0);

        // Long-pipe push, written one cycle later
        lp(1, 7, 32'hDEAD_BEEF, 0);
        smp();
        check("lp7_push_wen", wb.wbck_dest_wen, 0);
        cyc();
        lp(0, 0, 0, 0);
        smp();
        check("lp7_wen", wb.wbck_dest_wen, 1);
        check("lp7_idx", wb.wbck_dest_idx, 7);
        check("lp7_dat", wb.wbck_dest_dat, 32'hDEAD_BEEF);
        cyc();
        smp();
        check("lp7_empty", wb.longp_empty, 1);

        // Fill FIFO under an ALU stream, then drain incl. a faulted entry
        cyc();
        alu(1, 9);
        lp(1, 3, 32'h0000_0333, 0);
        cyc();
        alu(1, 9);
        lp(1, 4, 32'h0000_0444, 1);
        cyc();
        alu(1, 9);
        lp(0, 0, 0, 0);
        smp();
        check("fill_full", wb.longp_full, 1);
        check("fill_lp_rdy", wb.longp_wbck_i_ready, 0);
        check("fill_idx", wb.wbck_dest_idx, 9);
        cyc();
        alu(1, 9);
        lp(1, 12, 32'h0000_0CCC, 0);
        smp();
        check("full_lp_rdy", wb.longp_wbck_i_ready, 0);
        cyc();
        alu(0, 0);
        lp(0, 0, 0, 0);
        smp();
        check("drain3_idx", wb.wbck_dest_idx, 3);
        check("drain3_wen", wb.wbck_dest_wen, 1);
        cyc();
        smp();
        check("drain4_err", wb.longp_err_o, 1);
        check("drain4_wen", wb.wbck_dest_wen, 0);
        cyc();
        smp();
        check("drain_empty", wb.longp_empty, 1);
        check("drain_err_low", wb.longp_err_o, 0);

        // Starvation behaviour with the FIFO head idx 8
        cyc();
        alu(1, 11);
        lp(1, 8, 32'h0000_0888, 0);
        cyc();
        lp(0, 0, 0, 0);
`ifdef E203_WBCK_STARVE_GUARD_EN
        for (int i = 0; i < STARVE_MAX; i++) begin
            alu(1, 11);
            smp();
            check("sg_block_rdy", wb.alu_wbck_i_ready, 1);
            check("sg_block_idx", wb.wbck_dest_idx, 11);
            cyc();
        end
        alu(1, 11);
        smp();
        check("sg_force_rdy", wb.alu_wbck_i_ready, 0);
        check("sg_force_wen", wb.wbck_dest_wen, 1);
        check("sg_force_idx", wb.wbck_dest_idx, 8);
        cyc();
        alu(1, 11);
        smp();
        check("sg_after_empty", wb.longp_empty, 1);
        check("sg_after_rdy", wb.alu_wbck_i_ready, 1);
        cyc();
        alu(0, 0);
`else
        for (int i = 0; i < 10; i++) begin
            alu(1, 11);
            smp();
            check("st_rdy", wb.alu_wbck_i_ready, 1);
            check("st_idx", wb.wbck_dest_idx, 11);
            check("st_nonempty", wb.longp_empty, 0);
            cyc();
        end
        alu(0, 0);
        smp();
        check("st_release_idx", wb.wbck_dest_idx, 8);
        cyc();
`endif
        smp();
        check("st_empty", wb.longp_empty, 1);

        // Asynchronous reset with two entries queued
        cyc();
        alu(1, 13);
        lp(1, 20, 32'h0000_0020, 0);
        cyc();
        alu(1, 13);
        lp(1, 21, 32'h0000_0021, 0);
        cyc();
        alu(1, 13);
        lp(0, 0, 0, 0);
        smp();
        check("pre_rst_full", wb.longp_full, 1);
        cyc();
        #2;
        alu(0, 0);
        wb.alu_wbck_i_dat = '0;
        rst_n = 1'b0;
        lp_q.delete();
        #1;
        check("arst_empty", wb.longp_empty, 1);
        check("arst_full", wb.longp_full, 0);
        check("arst_wen", wb.wbck_dest_wen, 0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            smp();
            check("post_rst_wen", wb.wbck_dest_wen, 0);
            check("post_rst_empty", wb.longp_empty, 1);
            cyc();
        end

        check("sb_drained", lp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
